buffer_readout_ctrl: RTL and testbench

BUFFER_READOUT_CTRL -- requirements
Module: buffer_readout_ctrl

---
 rtl/buffer_readout_ctrl_if.sv | 26 ++
 rtl/buffer_readout_ctrl.sv | 173 +++++++++++++++++
 tb/tb_buffer_readout_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_readout_ctrl_if.sv
// RAM read port and sample stream of the ping-pong buffer readout block.
// The master side is the controller; the slave side is the RAM and the stream sink.
interface buffer_readout_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  rd_en_o;
    logic [ADDR_WIDTH-1:0] rd_addr_o;
    logic [DATA_WIDTH-1:0] rd_data_i;
    logic                  rd_data_valid_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_last_o;
    logic                  out_buf_id_o;

    modport master (
        output rd_en_o, rd_addr_o, out_valid_o, out_data_o, out_last_o, out_buf_id_o,
        input  rd_data_i, rd_data_valid_i, out_ready_i
    );

    modport slave (
        input  rd_en_o, rd_addr_o, out_valid_o, out_data_o, out_last_o, out_buf_id_o,
        output rd_data_i, rd_data_valid_i, out_ready_i
    );
endinterface

// File: rtl/buffer_readout_ctrl.sv
// Streams a filled half-buffer out of RAM; first sample 3 cycles after the ready pulse, 1 sample/cycle.
// Reads are throttled so a 2-entry skid FIFO absorbs any out_ready_i stall without loss.
module buffer_readout_ctrl #(
    parameter int DATA_WIDTH      = 16,
    parameter int SAMPLES_PER_BUF = 256,
    parameter int ADDR_WIDTH      = $clog2(SAMPLES_PER_BUF)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  buf_ready_pulse_i,
    input  logic                  buf_ready_id_i,
    input  logic                  clr_overrun_i,
    buffer_readout_ctrl_if.master bus,
    output logic                  busy_o,
    output logic [7:0]            overrun_cnt_o
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLES_PER_BUF - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] dat;
    } smp_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  cur_id_q, cur_id_d;
    logic                  pend_q, pend_d;
    logic                  pend_id_q, pend_id_d;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic [7:0]            ovr_q;

    smp_t                  fifo_mem [2];
    smp_t                  head;
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            fifo_cnt_q;

    logic                  pulse_acc;
    logic                  push, pop;
    logic                  rd_en;
    logic                  drain_exit;
    logic [2:0]            occupancy;

    assign pulse_acc = enable_i & buf_ready_pulse_i;
    assign push      = bus.rd_data_valid_i;
    assign pop       = bus.out_valid_o & bus.out_ready_i;
    assign head      = fifo_mem[rd_ptr_q];

    // Samples already held plus the one still in the RAM pipe, after this cycle's pop.
    assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign bus.rd_en_o      = rd_en;
    assign bus.rd_addr_o    = addr_q;
    assign bus.out_valid_o  = (fifo_cnt_q != 2'd0);
    assign bus.out_data_o   = head.dat;
    assign bus.out_last_o   = bus.out_valid_o & head.last;
    assign bus.out_buf_id_o = cur_id_q;
    assign busy_o           = (state_q != IDLE);
    assign overrun_cnt_o    = ovr_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cur_id_d   = cur_id_q;
        pend_d     = pend_q;
        pend_id_d  = pend_id_q;
        rd_en      = 1'b0;
        drain_exit = 1'b0;
        case (state_q)
            IDLE: begin
                if (pulse_acc) begin
                    state_d  = READ;
                    addr_d   = '0;
                    cur_id_d = buf_ready_id_i;
                end
            end
            READ: begin
                rd_en = (occupancy < 3'd2);
                if (rd_en) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
                if (pulse_acc) begin
                    pend_d    = 1'b1;
                    pend_id_d = buf_ready_id_i;
                end
            end
            DRAIN: begin
                drain_exit = pop & head.last;
                if (drain_exit) begin
                    // A pulse landing on the exit edge is the newest request and wins over the stored one.
                    if (pulse_acc || pend_q) begin
                        state_d  = READ;
                        addr_d   = '0;
                        cur_id_d = pulse_acc ? buf_ready_id_i : pend_id_q;
                        pend_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (pulse_acc) begin
                    pend_d    = 1'b1;
                    pend_id_d = buf_ready_id_i;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            cur_id_q        <= 1'b0;
            pend_q          <= 1'b0;
            pend_id_q       <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            cur_id_q        <= cur_id_d;
            pend_q          <= pend_d;
            pend_id_q       <= pend_id_d;
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en & (addr_q == LAST_ADDR);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovr_q <= 8'd0;
        end else if (clr_overrun_i) begin
            ovr_q <= 8'd0;
        end else if (busy_o && pulse_acc && !drain_exit && (ovr_q != 8'hFF)) begin
            ovr_q <= ovr_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO never presents its head.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{last: inflight_last_q, dat: bus.rd_data_i};
        end
    end
endmodule

// File: tb/tb_buffer_readout_ctrl.sv
// Directed bench for buffer_readout_ctrl with a 1-cycle-latency RAM model.
module tb_buffer_readout_ctrl;
    localparam int DW  = 16;
    localparam int SPB = 256;
    localparam int AW  = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, pulse, pid, clr;
    logic       busy;
    logic [7:0] ovr;

    always #5 clk = ~clk;

    buffer_readout_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    buffer_readout_ctrl #(
        .DATA_WIDTH(DW), .SAMPLES_PER_BUF(SPB), .ADDR_WIDTH(AW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
        .buf_ready_pulse_i(pulse), .buf_ready_id_i(pid),
        .clr_overrun_i(clr), .bus(bus), .busy_o(busy), .overrun_cnt_o(ovr)
    );

    function automatic logic [DW-1:0] ram_val(input logic id, input logic [7:0] a);
        return {(id ? 8'hA5 : 8'h3C), a};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data_valid_i <= 1'b0;
            bus.rd_data_i       <= '0;
        end else begin
            bus.rd_data_valid_i <= bus.rd_en_o;
            if (bus.rd_en_o) bus.rd_data_i <= ram_val(bus.out_buf_id_o, bus.rd_addr_o);
        end
    end

    int   n_vec = 0, n_err = 0;
    int   p_n, en_off, first_vld, last_cyc;
    int   p_cyc [3];
    logic p_id  [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rd_en"},   bus.rd_en_o, 0);
        chk({tag, "_valid"},   bus.out_valid_o, 0);
        chk({tag, "_last"},    bus.out_last_o, 0);
        chk({tag, "_buf_id"},  bus.out_buf_id_o, 0);
        chk({tag, "_busy"},    busy, 0);
        chk({tag, "_overrun"}, ovr, 0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
        pulse = 1'b0;
        clr   = 1'b0;
    endtask

    // Consumes one buffer; cycle 1 is the cycle after the pulse / previous buffer exit.
    task automatic stream(input logic id, input bit rnd, input int rst_idx, input int budget);
        int idx, cyc;
        bit stalled, done;
        logic [DW-1:0] held_d;
        logic held_l;
        idx = 0; cyc = 0; stalled = 0; done = 0; held_d = '0; held_l = 1'b0;
        first_vld = -1; last_cyc = -1;
        while (!done && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            pulse = 1'b0;
            bus.out_ready_i = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            for (int k = 0; k < p_n; k++) begin
                if (p_cyc[k] == cyc) begin
                    pulse = 1'b1;
                    pid   = p_id[k];
                end
            end
            if (cyc == en_off) enable = 1'b0;
            if (rst_idx >= 0 && idx == rst_idx) begin
                rst_n = 1'b0;
                pulse = 1'b0;
                #1;
                chk_reset("midrst");
                done = 1;
            end else begin
                @(negedge clk);
                if (bus.out_valid_o) begin
                    if (first_vld < 0) first_vld = cyc;
                    if (stalled) begin
                        chk("hold_dat", bus.out_data_o, held_d);
                        chk("hold_last", bus.out_last_o, held_l);
                    end
                    if (bus.out_ready_i) begin
                        chk("dat", bus.out_data_o, ram_val(id, idx[7:0]));
                        chk("buf_id", bus.out_buf_id_o, id);
                        chk("last", bus.out_last_o, idx == SPB - 1);
                        if (idx == SPB - 1) begin
                            done = 1;
                            last_cyc = cyc;
                        end
                        idx++;
                        stalled = 0;
                    end else begin
                        stalled = 1;
                        held_d  = bus.out_data_o;
                        held_l  = bus.out_last_o;
                    end
                end
            end
        end
        if (!done) chk("stream_timeout", idx, SPB);
    endtask

    initial begin
        int stray;
        enable = 1'b1; pulse = 1'b0; pid = 1'b0; clr = 1'b0;
        bus.out_ready_i = 1'b1;
        p_n = 0; en_off = -1; rst_n = 1'b0;
        #12;
        chk_reset("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_busy", busy, 0);
        chk("idle_valid", bus.out_valid_o, 0);

        // Pulse with enable low must be ignored.
        enable = 1'b0; pulse = 1'b1; pid = 1'b1;
        tick(); tick();
        chk("disabled_busy", busy, 0);
        enable = 1'b1;

        // Basic buffer, sink always ready.
        pulse = 1'b1; pid = 1'b1;
        stream(1'b1, 1'b0, -1, 400);
        chk("a_first_valid", first_vld, 3);
        chk("a_last_cycle", last_cyc, 258);
        tick();
        chk("a_busy_after", busy, 0);
        chk("a_valid_after", bus.out_valid_o, 0);
        chk("a_overrun", ovr, 0);

        // Random backpressure.
        pulse = 1'b1; pid = 1'b0;
        stream(1'b0, 1'b1, -1, 3000);
        bus.out_ready_i = 1'b1;
        tick();
        chk("b_busy_after", busy, 0);

        // One overrun mid-readout, pending buffer follows immediately.
        p_n = 1; p_cyc[0] = 50; p_id[0] = 1'b0;
        pulse = 1'b1; pid = 1'b1;
        stream(1'b1, 1'b0, -1, 400);
        chk("c_overrun", ovr, 1);
        p_n = 0;
        stream(1'b0, 1'b0, -1, 400);
        chk("c_pend_first", first_vld, 3);
        chk("c_pend_last", last_cyc, 258);
        tick();
        chk("c_busy_after", busy, 0);
        chk("c_overrun_kept", ovr, 1);
        clr = 1'b1;
        tick();
        chk("c_clear", ovr, 0);

        // Three overruns, newest ID wins.
        p_n = 3;
        p_cyc[0] = 20; p_id[0] = 1'b0;
        p_cyc[1] = 40; p_id[1] = 1'b0;
        p_cyc[2] = 60; p_id[2] = 1'b1;
        pulse = 1'b1; pid = 1'b0;
        stream(1'b0, 1'b0, -1, 400);
        chk("d_overrun", ovr, 3);
        p_n = 0;
        stream(1'b1, 1'b0, -1, 400);
        chk("d_pend_first", first_vld, 3);
        tick();
        chk("d_busy_after", busy, 0);
        clr = 1'b1;
        tick();

        // Pulse on the drain-exit cycle is pending, not an overrun.
        p_n = 1; p_cyc[0] = 258; p_id[0] = 1'b1;
        pulse = 1'b1; pid = 1'b0;
        stream(1'b0, 1'b0, -1, 400);
        p_n = 0;
        stream(1'b1, 1'b0, -1, 400);
        chk("e_overrun", ovr, 0);
        chk("e_pend_first", first_vld, 3);
        tick();
        chk("e_busy_after", busy, 0);

        // Saturation, then clear beats a coincident pulse.
        pulse = 1'b1; pid = 1'b0;
        repeat (300) begin
            @(posedge clk); #1;
            pulse = 1'b1;
        end
        chk("f_saturated", ovr, 255);
        @(posedge clk); #1;
        chk("f_sat_hold", ovr, 255);
        clr = 1'b1;
        @(posedge clk); #1;
        chk("f_clr_priority", ovr, 0);
        pulse = 1'b0; clr = 1'b0;
        for (int i = 0; i < 1500 && busy; i++) tick();
        chk("f_back_idle", busy, 0);
        chk("f_overrun_zero", ovr, 0);

        // Enable drops mid-buffer: buffer completes, earlier pending kept, later pulse ignored.
        p_n = 2;
        p_cyc[0] = 30;  p_id[0] = 1'b0;
        p_cyc[1] = 100; p_id[1] = 1'b1;
        en_off = 60;
        pulse = 1'b1; pid = 1'b1;
        stream(1'b1, 1'b0, -1, 400);
        chk("g_overrun", ovr, 1);
        p_n = 0; en_off = -1;
        stream(1'b0, 1'b0, -1, 400);
        chk("g_pend_first", first_vld, 3);
        tick();
        chk("g_busy_after", busy, 0);
        chk("g_overrun_kept", ovr, 1);
        enable = 1'b1; clr = 1'b1;
        tick();

        // Reset at sample 100.
        pulse = 1'b1; pid = 1'b1;
        stream(1'b1, 1'b0, 100, 400);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid_o) stray++;
        end
        chk("h_stray_valid", stray, 0);
        chk("h_busy", busy, 0);

        // Recovery after reset.
        pulse = 1'b1; pid = 1'b0;
        stream(1'b0, 1'b0, -1, 400);
        chk("h_recover_first", first_vld, 3);
        tick();
        chk("h_recover_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
